// File: rtl/issue_select.sv
// Issue select: per-FU round-robin pick among ready rows, with FU occupancy
// tracking and an in-order return queue that hands granted rows back for reuse.
module issue_select #(
   parameter int NUM_ROWS = 8,
   parameter int NUM_FUS  = 4,
   parameter int OCC_W    = 4,
   localparam int RW      = $clog2(NUM_ROWS),
   localparam int FW      = $clog2(NUM_FUS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alloc_en,
   input  logic [RW-1:0]          alloc_row,
   input  logic [FW-1:0]          alloc_fu,
   input  logic [OCC_W-1:0]       alloc_occ,
   input  logic [NUM_ROWS-1:0]    request_vector,
   input  logic [NUM_FUS-1:0]     fu_stall,
   output logic [NUM_FUS-1:0]     grant_valid,
   output logic [NUM_FUS*RW-1:0]  grant_row,
   output logic                   free_en,
   output logic [RW-1:0]          free_row,
   output logic [NUM_ROWS-1:0]    entry_valid,
   output logic                   alloc_err
);

   logic [NUM_ROWS-1:0]   valid_q, valid_d;
   logic [FW-1:0]         fu_q     [NUM_ROWS];
   logic [FW-1:0]         fu_d     [NUM_ROWS];
   logic [OCC_W-1:0]      occ_q    [NUM_ROWS];
   logic [OCC_W-1:0]      occ_d    [NUM_ROWS];
   logic [RW-1:0]         rr_ptr_q [NUM_FUS];
   logic [RW-1:0]         rr_ptr_d [NUM_FUS];
   logic [OCC_W-1:0]      busy_q   [NUM_FUS];
   logic [OCC_W-1:0]      busy_d   [NUM_FUS];
   logic [NUM_FUS-1:0]    grant_valid_q, grant_valid_d;
   logic [NUM_FUS*RW-1:0] grant_row_q, grant_row_d;
   logic [RW-1:0]         fifo_q   [NUM_ROWS];
   logic [RW-1:0]         fifo_d   [NUM_ROWS];
   logic [RW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [RW:0]           count_q, count_d;
   logic                  free_en_q, free_en_d;
   logic [RW-1:0]         free_row_q, free_row_d;
   logic                  alloc_err_q, alloc_err_d;
   logic [NUM_FUS-1:0]    sel_hit_s;
   logic [RW-1:0]         sel_row_s [NUM_FUS];

   // Round-robin pick per FU; only rows already valid can win, so a same-cycle alloc never grants.
   always_comb begin : sel_blk
      logic [RW-1:0] idx;
      logic          take;
      idx  = '0;
      take = 1'b0;
      for (int f = 0; f < NUM_FUS; f++) begin
         sel_hit_s[f] = 1'b0;
         sel_row_s[f] = '0;
         for (int k = 0; k < NUM_ROWS; k++) begin
            idx  = rr_ptr_q[f] + RW'(k);
            take = !fu_stall[f] && (busy_q[f] == '0) && !sel_hit_s[f] &&
                   valid_q[idx] && request_vector[idx] && (fu_q[idx] == FW'(f));
            sel_hit_s[f] = sel_hit_s[f] | take;
            sel_row_s[f] = take ? idx : sel_row_s[f];
         end
      end
   end

   // Row table, per-FU pointers/occupancy, grant outputs and return queue next state.
   always_comb begin : nxt_blk
      logic [RW-1:0] wr;
      logic [RW:0]   push_cnt;
      valid_d     = valid_q;
      fu_d        = fu_q;
      occ_d       = occ_q;
      alloc_err_d = alloc_err_q;
      fifo_d      = fifo_q;
      grant_row_d = '0;
      wr          = tail_q;
      push_cnt    = '0;

      if (alloc_en) begin
         if (valid_q[alloc_row]) begin
            alloc_err_d = 1'b1;
         end else begin
            valid_d[alloc_row] = 1'b1;
            fu_d[alloc_row]    = alloc_fu;
            occ_d[alloc_row]   = alloc_occ;
         end
      end else begin
         alloc_err_d = alloc_err_q;
      end

      // Ascending FU order fixes the queue order of same-cycle grants.
      for (int f = 0; f < NUM_FUS; f++) begin
         grant_row_d[f*RW +: RW] = sel_row_s[f];
         if (sel_hit_s[f]) begin
            valid_d[sel_row_s[f]] = 1'b0;
            rr_ptr_d[f]           = sel_row_s[f] + RW'(1);
            busy_d[f]             = occ_q[sel_row_s[f]];
            fifo_d[wr]            = sel_row_s[f];
            wr                    = wr + RW'(1);
            push_cnt              = push_cnt + (RW+1)'(1);
         end else begin
            rr_ptr_d[f] = rr_ptr_q[f];
            busy_d[f]   = (busy_q[f] == '0) ? busy_q[f] : busy_q[f] - OCC_W'(1);
         end
      end
      grant_valid_d = sel_hit_s;

      if (count_q != '0) begin
         free_en_d  = 1'b1;
         free_row_d = fifo_q[head_q];
         head_d     = head_q + RW'(1);
      end else begin
         free_en_d  = 1'b0;
         free_row_d = '0;
         head_d     = head_q;
      end
      tail_d  = wr;
      count_d = count_q + push_cnt - {{RW{1'b0}}, free_en_d};
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q       <= '0;
         grant_valid_q <= '0;
         grant_row_q   <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         free_en_q     <= 1'b0;
         free_row_q    <= '0;
         alloc_err_q   <= 1'b0;
         for (int r = 0; r < NUM_ROWS; r++) begin
            fu_q[r]   <= '0;
            occ_q[r]  <= '0;
            fifo_q[r] <= '0;
         end
         for (int f = 0; f < NUM_FUS; f++) begin
            rr_ptr_q[f] <= '0;
            busy_q[f]   <= '0;
         end
      end else begin
         valid_q       <= valid_d;
         fu_q          <= fu_d;
         occ_q         <= occ_d;
         fifo_q        <= fifo_d;
         rr_ptr_q      <= rr_ptr_d;
         busy_q        <= busy_d;
         grant_valid_q <= grant_valid_d;
         grant_row_q   <= grant_row_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         free_en_q     <= free_en_d;
         free_row_q    <= free_row_d;
         alloc_err_q   <= alloc_err_d;
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_row   = grant_row_q;
   assign free_en     = free_en_q;
   assign free_row    = free_row_q;
   assign entry_valid = valid_q;
   assign alloc_err   = alloc_err_q;

endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Parameters
REQ-001 SHALL have parameter NUM_ROWS, default 8, number of scheduler entries (power of 2).
REQ-002 SHALL have parameter NUM_FUS, default 4, number of functional units (power of 2).
REQ-003 SHALL have parameter OCC_W, default 4, width of the FU occupancy count.

Interface (RW = log2 NUM_ROWS, FW = log2 NUM_FUS)
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 alloc_en  in  1  write row table entry this cycle.
REQ-007 alloc_row  in  RW  row being allocated.
REQ-008 alloc_fu  in  FW  FU the entry must issue to.
REQ-009 alloc_occ  in  OCC_W  cycles the FU stays blocked after issue; 0 = fully pipelined.
REQ-010 request_vector  in  NUM_ROWS  per-row operands-ready from wakeup logic.
REQ-011 fu_stall  in  NUM_FUS  per-FU back-pressure; a stalled FU receives no grant.
REQ-012 grant_valid  out  NUM_FUS  per-FU issue strobe, registered.
REQ-013 grant_row  out  NUM_FUS*RW  row granted to FU f in slice [f*RW +: RW], registered.
REQ-014 free_en  out  1  one-cycle pulse returning a row to the free-entry queue.
REQ-015 free_row  out  RW  row being returned; meaningful only while free_en is high.
REQ-016 entry_valid  out  NUM_ROWS  per-row allocated-and-not-issued flags.
REQ-017 alloc_err  out  1  sticky; set when alloc_en targets a row already valid.

Function
REQ-018 Row table SHALL hold valid, fu, occ per row; alloc_en SHALL set valid and capture fu/occ at the next edge.
REQ-019 Allocation to a valid row SHALL be ignored (table unchanged) and SHALL set alloc_err.
REQ-020 Row r SHALL be eligible for FU f when valid[r], fu[r]==f and request_vector[r] are all high in the same cycle.
REQ-021 FU f SHALL be grantable when fu_stall[f] is low and busy_cnt[f] is 0.
REQ-022 Each grantable FU with at least one eligible row SHALL select the first eligible row searching upward from rr_ptr[f], wrapping from NUM_ROWS-1 to 0.
REQ-023 Selection SHALL register grant_valid[f]/grant_row[f] at the next edge (1-cycle latency); grant_valid[f] SHALL be 0 otherwise.
REQ-024 On the same edge, the granted row SHALL have valid cleared and rr_ptr[f] SHALL become (granted row + 1) mod NUM_ROWS; a row SHALL never be granted twice.
REQ-025 On grant, busy_cnt[f] SHALL load occ of the granted row; while nonzero it SHALL decrement by 1 per cycle, independent of fu_stall.
REQ-026 Rows are FU-exclusive, so several FUs MAY grant in one cycle without conflict.
REQ-027 Each granted row SHALL be pushed into an internal return FIFO of depth NUM_ROWS on the grant edge; multiple same-cycle pushes SHALL be ordered by ascending FU index.
REQ-028 The FIFO SHALL pop one row per cycle when non-empty, registering free_en=1 and free_row; a row is pushed at grant edge E and leaves no earlier than edge E+1; FIFO cannot overflow because rows are unique.
REQ-029 alloc_en with request_vector high for the same row in the same cycle SHALL NOT grant that cycle (row not yet valid).
REQ-030 alloc_en for a row still in the return FIFO SHALL be accepted (valid already cleared); the FIFO entry still drains.

Reset
REQ-031 While rst is low: grant_valid=0, grant_row=0, free_en=0, free_row=0, entry_valid=0, alloc_err=0, all rr_ptr=0, all busy_cnt=0, return FIFO empty.
REQ-032 Reset assertion mid-operation SHALL discard all in-flight grants and pending returns; first grant possible on the second edge after rst rises.

Verification
REQ-033 Alloc rows 2,5 to FU1 occ 0, request_vector=0x24 -> cycle+1 grant_row[1]=2; cycle+2 grant_row[1]=5; free_row 2 then 5 on successive cycles.
REQ-034 rr_ptr[0]=6, rows 1,6,7 valid on FU0 and requesting -> grants in order 6,7,1 (wrap).
REQ-035 Row 3 on FU2 occ 3, row 4 on FU2 ready -> grant 3, FU2 idle 3 cycles, grant 4 on 4th cycle after; fu_stall[2] high during window delays further.
REQ-036 Rows 0,1,2,3 on FUs 0..3 all ready same cycle -> four grant_valid together; free_row 0,1,2,3 on four consecutive cycles.
REQ-037 alloc_en to row 5 while valid -> table unchanged, alloc_err=1 until reset.
REQ-038 rst low with 3 rows valid and 2 in return FIFO -> all outputs 0 immediately; no free_en after release.
